// File: rtl/hangmaze_pkg.sv
// Shared keycode constants, direction/mode types and the maze key map for the
// keyboard-to-game-event path.
package hangmaze_pkg;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_Z     = 8'h1D;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;

  typedef enum logic [3:0] {
    DIR_NONE  = 4'h0,
    DIR_UP    = 4'h1,
    DIR_DOWN  = 4'h2,
    DIR_LEFT  = 4'h4,
    DIR_RIGHT = 4'h8
  } dir_t;

  typedef enum logic {
    MODE_MAZE    = 1'b0,
    MODE_HANGMAN = 1'b1
  } mode_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } dir_map_t;

  function automatic dir_map_t map_dir(input logic [7:0] kc);
    dir_map_t m;
    m.hit = 1'b1;
    case (kc)
      KC_W, KC_UP:    m.dir = DIR_UP;
      KC_S, KC_DOWN:  m.dir = DIR_DOWN;
      KC_A, KC_LEFT:  m.dir = DIR_LEFT;
      KC_D, KC_RIGHT: m.dir = DIR_RIGHT;
      default: begin
        m.hit = 1'b0;
        m.dir = DIR_NONE;
      end
    endcase
    return m;
  endfunction

  function automatic logic is_letter(input logic [7:0] kc);
    return (kc >= KC_A) && (kc <= KC_Z);
  endfunction

endpackage

// File: rtl/typematic_timer.sv
// Auto-repeat interval counter: counts the initial hold delay (phase 0) or the
// repeat period (phase 1) and restarts itself on terminal count.
module typematic_timer #(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic phase,
  output logic tick
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == (phase ? RATE_TC : DELAY_TC));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keycode_move_decoder.sv
// Turns the per-frame HID keycode into maze move events (with auto-repeat) or
// hangman letter guesses, each behind a one-entry valid/ready buffer.
//
//   state  | meaning
//   IDLE   | no mapped maze key held
//   DELAY  | key held, waiting for the first auto-repeat
//   REPEAT | key held, emitting repeats at the repeat rate
module keycode_move_decoder
  import hangmaze_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       game_mode,
  output logic       dir_valid,
  input  logic       dir_ready,
  output logic [3:0] direction,
  output logic       dir_repeat,
  output logic       guess_valid,
  input  logic       guess_ready,
  output logic [4:0] guess_letter,
  output logic       overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

  state_t   state, state_next;
  logic [7:0] kc_q, kc_prev;
  mode_t    mode_q;
  logic     lockout;
  dir_map_t kc_map;
  logic     maze, kc_mapped, press, mode_change, blocked;
  logic     tick, timer_clear;
  logic     emit_dir, emit_fresh, emit_guess;

  always_comb begin
    kc_map      = map_dir(kc_q);
    maze        = (mode_q == MODE_MAZE);
    kc_mapped   = maze ? kc_map.hit : is_letter(kc_q);
    press       = (kc_q != kc_prev) && kc_mapped;
    mode_change = (mode_t'(game_mode) != mode_q);
    blocked     = lockout || mode_change;
  end

  typematic_timer #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_timer (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clear  (timer_clear),
    .phase  (state == ST_REPEAT),
    .tick   (tick)
  );

  always_comb begin
    state_next  = state;
    emit_dir    = 1'b0;
    emit_fresh  = 1'b0;
    timer_clear = 1'b0;
    if (blocked || !maze) begin
      state_next  = ST_IDLE;
      timer_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          timer_clear = 1'b1;
          if (press) begin
            emit_dir   = 1'b1;
            emit_fresh = 1'b1;
            state_next = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!kc_mapped) begin
            state_next  = ST_IDLE;
            timer_clear = 1'b1;
          end else if (press) begin
            emit_dir    = 1'b1;
            emit_fresh  = 1'b1;
            timer_clear = 1'b1;
            state_next  = ST_DELAY;
          end else if (tick) begin
            emit_dir   = 1'b1;
            state_next = ST_REPEAT;
          end
        end
        default: begin
          state_next  = ST_IDLE;
          timer_clear = 1'b1;
        end
      endcase
    end
    emit_guess = !maze && !blocked && press;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kc_q    <= KC_NONE;
      kc_prev <= KC_NONE;
      mode_q  <= MODE_MAZE;
      lockout <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      kc_q    <= keycode;
      kc_prev <= kc_q;
      mode_q  <= mode_t'(game_mode);
      state   <= state_next;
      // A key held across the mode switch must be released before it counts.
      if (mode_change) begin
        lockout <= 1'b1;
      end else if (kc_q == KC_NONE) begin
        lockout <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_valid    <= 1'b0;
      direction    <= 4'h0;
      dir_repeat   <= 1'b0;
      guess_valid  <= 1'b0;
      guess_letter <= 5'd0;
      overrun      <= 1'b0;
    end else if (mode_change) begin
      dir_valid   <= 1'b0;
      guess_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Repeats never displace an unaccepted event; fresh presses always do.
      if (emit_dir && (emit_fresh || !dir_valid || dir_ready)) begin
        dir_valid  <= 1'b1;
        direction  <= kc_map.dir;
        dir_repeat <= !emit_fresh;
      end else if (dir_valid && dir_ready) begin
        dir_valid <= 1'b0;
      end
      if (emit_guess) begin
        guess_valid  <= 1'b1;
        guess_letter <= 5'(kc_q - KC_A);
      end else if (guess_valid && guess_ready) begin
        guess_valid <= 1'b0;
      end
      overrun <= (emit_fresh && dir_valid && !dir_ready) ||
                 (emit_guess && guess_valid && !guess_ready);
    end
  end

endmodule

// File: tb/tb_keycode_move_decoder.sv
// Directed bench for keycode_move_decoder with short repeat timing
// (REPEAT_DELAY=8, REPEAT_RATE=4).
module tb_keycode_move_decoder;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       game_mode;
  logic       dir_valid;
  logic       dir_ready;
  logic [3:0] direction;
  logic       dir_repeat;
  logic       guess_valid;
  logic       guess_ready;
  logic [4:0] guess_letter;
  logic       overrun;

  int tests;
  int fails;

  int         dev_t[16];
  logic [3:0] dev_dir[16];
  logic       dev_rep[16];
  int         dev_n;
  int         gev_t[16];
  logic [4:0] gev_l[16];
  int         gev_n;
  int         ov_n;

  keycode_move_decoder #(
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .keycode     (keycode),
    .game_mode   (game_mode),
    .dir_valid   (dir_valid),
    .dir_ready   (dir_ready),
    .direction   (direction),
    .dir_repeat  (dir_repeat),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess_letter(guess_letter),
    .overrun     (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Holds kc1, optionally switches to kc2, releases, and logs accepted events.
  task automatic run_hold(input logic [7:0] kc1, input int switch_at, input logic [7:0] kc2,
                          input int release_at, input int n_cycles);
    dev_n   = 0;
    gev_n   = 0;
    ov_n    = 0;
    keycode = kc1;
    for (int i = 1; i <= n_cycles; i++) begin
      step();
      if (dir_valid && dir_ready && dev_n < 16) begin
        dev_t[dev_n]   = i;
        dev_dir[dev_n] = direction;
        dev_rep[dev_n] = dir_repeat;
        dev_n++;
      end
      if (guess_valid && guess_ready && gev_n < 16) begin
        gev_t[gev_n] = i;
        gev_l[gev_n] = guess_letter;
        gev_n++;
      end
      if (overrun) ov_n++;
      if (i == switch_at) keycode = kc2;
      if (i == release_at) keycode = 8'h00;
    end
  endtask

  task automatic set_mode(input logic m);
    keycode   = 8'h00;
    game_mode = m;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    step();
    step();
    tests++;
    if ({dir_valid, direction, dir_repeat, guess_valid, guess_letter, overrun} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {dir_valid, direction, dir_repeat, guess_valid, guess_letter, overrun});
    end
    Reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_typematic();
    int       exp_t[4] = '{2, 10, 14, 18};
    logic     exp_r[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_hold(8'h1A, 0, 8'h00, 20, 28);
    tests++;
    if (dev_n !== 4) begin
      fails++;
      $display("FAIL typematic_count: got %0d expected 4", dev_n);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (dev_t[k] !== exp_t[k] || dev_dir[k] !== 4'h1 || dev_rep[k] !== exp_r[k]) begin
        fails++;
        $display("FAIL typematic_ev%0d: got t=%0d dir=%h rep=%b expected t=%0d dir=1 rep=%b",
                 k, dev_t[k], dev_dir[k], dev_rep[k], exp_t[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_switch();
    int         exp_t[3] = '{2, 7, 15};
    logic [3:0] exp_d[3] = '{4'h4, 4'h8, 4'h8};
    logic       exp_r[3] = '{1'b0, 1'b0, 1'b1};
    run_hold(8'h50, 5, 8'h4F, 17, 22);
    tests++;
    if (dev_n !== 3) begin
      fails++;
      $display("FAIL switch_count: got %0d expected 3", dev_n);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (dev_t[k] !== exp_t[k] || dev_dir[k] !== exp_d[k] || dev_rep[k] !== exp_r[k]) begin
        fails++;
        $display("FAIL switch_ev%0d: got t=%0d dir=%h rep=%b expected t=%0d dir=%h rep=%b",
                 k, dev_t[k], dev_dir[k], dev_rep[k], exp_t[k], exp_d[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_overrun();
    dir_ready = 1'b0;
    run_hold(8'h52, 3, 8'h51, 22, 26);
    tests++;
    if (ov_n !== 1) begin
      fails++;
      $display("FAIL overrun_pulses: got %0d expected 1", ov_n);
    end
    tests++;
    if (dir_valid !== 1'b1 || direction !== 4'h2 || dir_repeat !== 1'b0) begin
      fails++;
      $display("FAIL overrun_held: got valid=%b dir=%h rep=%b expected valid=1 dir=2 rep=0",
               dir_valid, direction, dir_repeat);
    end
    dir_ready = 1'b1;
    step();
    tests++;
    if (dir_valid !== 1'b0) begin
      fails++;
      $display("FAIL overrun_drain: got valid=%b expected 0", dir_valid);
    end
  endtask

  task automatic test_hangman();
    set_mode(1'b1);
    run_hold(8'h04, 30, 8'h1D, 35, 40);
    tests++;
    if (gev_n !== 2 || dev_n !== 0) begin
      fails++;
      $display("FAIL hangman_count: got guesses=%0d moves=%0d expected 2 and 0", gev_n, dev_n);
    end
    tests++;
    if (gev_t[0] !== 2 || gev_l[0] !== 5'd0) begin
      fails++;
      $display("FAIL hangman_first: got t=%0d letter=%0d expected t=2 letter=0", gev_t[0], gev_l[0]);
    end
    tests++;
    if (gev_t[1] !== 32 || gev_l[1] !== 5'd25) begin
      fails++;
      $display("FAIL hangman_second: got t=%0d letter=%0d expected t=32 letter=25", gev_t[1], gev_l[1]);
    end
  endtask

  task automatic test_mode_change();
    int events;
    set_mode(1'b0);
    dir_ready = 1'b0;
    keycode   = 8'h07;
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (dir_valid !== 1'b1 || direction !== 4'h8) begin
      fails++;
      $display("FAIL mode_pending: got valid=%b dir=%h expected valid=1 dir=8", dir_valid, direction);
    end
    game_mode = 1'b1;
    step();
    tests++;
    if (dir_valid !== 1'b0 || guess_valid !== 1'b0) begin
      fails++;
      $display("FAIL mode_cleared: got dir_valid=%b guess_valid=%b expected 0 0", dir_valid, guess_valid);
    end
    dir_ready = 1'b1;
    events = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dir_valid || guess_valid) events++;
    end
    tests++;
    if (events !== 0) begin
      fails++;
      $display("FAIL mode_lockout: got %0d event cycles expected 0", events);
    end
    keycode = 8'h00;
    step();
    step();
    keycode = 8'h07;
    step();
    step();
    tests++;
    if (guess_valid !== 1'b1 || guess_letter !== 5'd3) begin
      fails++;
      $display("FAIL mode_relock: got valid=%b letter=%0d expected valid=1 letter=3", guess_valid, guess_letter);
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    set_mode(1'b0);
    dir_ready = 1'b0;
    keycode   = 8'h1A;
    for (int i = 0; i < 12; i++) step();
    tests++;
    if (dir_valid !== 1'b1 || dir_repeat !== 1'b0 || direction !== 4'h1) begin
      fails++;
      $display("FAIL midreset_pending: got valid=%b dir=%h rep=%b expected 1 1 0", dir_valid, direction, dir_repeat);
    end
    Reset_n = 1'b0;
    #1;
    tests++;
    if ({dir_valid, direction, dir_repeat, guess_valid, guess_letter, overrun} !== 13'd0) begin
      fails++;
      $display("FAIL midreset_async: got %b expected 0", {dir_valid, direction, dir_repeat, guess_valid, guess_letter, overrun});
    end
    step();
    Reset_n = 1'b1;
    step();
    tests++;
    if (dir_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_early: got valid=%b expected 0", dir_valid);
    end
    step();
    tests++;
    if (dir_valid !== 1'b1 || direction !== 4'h1 || dir_repeat !== 1'b0) begin
      fails++;
      $display("FAIL midreset_fresh: got valid=%b dir=%h rep=%b expected 1 1 0", dir_valid, direction, dir_repeat);
    end
    dir_ready = 1'b1;
    keycode   = 8'h00;
    step();
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    Reset_n     = 1'b0;
    keycode     = 8'h00;
    game_mode   = 1'b0;
    dir_ready   = 1'b1;
    guess_ready = 1'b1;
    test_reset();
    test_typematic();
    test_switch();
    test_overrun();
    test_hangman();
    test_mode_change();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
